// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI responder: mode decode helpers, the FSM state
// type and the synchroniser depth.
// ----------------------------------------------------------------------------
package spi_pkg;

   // Depth of the metastability synchroniser on the asynchronous SPI pins.
   localparam int SPI_SYNC_STAGES = 2;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_slave_state_t;

   // Clock polarity: SCLK idles high in modes 2 and 3.
   function automatic logic f_cpol(input int mode);
      return (mode == 2) || (mode == 3);
   endfunction

   // Clock phase: data is sampled on the trailing edge in modes 1 and 3.
   function automatic logic f_cpha(input int mode);
      return (mode == 1) || (mode == 3);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous pin into the i_Clk domain through a
// SPI_SYNC_STAGES-deep synchroniser, keeps one history flop and flags
// rising/falling edges of the synchronised level.
//
// Ports:
//   i_Clk    system clock
//   i_Rst    synchronous reset, active-high
//   i_async  asynchronous pin
//   o_rise   1 while the synchronised level has just gone 0->1
//   o_fall   1 while the synchronised level has just gone 1->0
//
// Parameter RST_VAL is the idle level of the pin.
// ----------------------------------------------------------------------------
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
)(
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SPI_SYNC_STAGES-1:0] sync_q, sync_d;
   logic                       hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[SPI_SYNC_STAGES-2:0], i_async};
      hist_d = sync_q[SPI_SYNC_STAGES-1];
   end

   // NOTE: flops use non-blocking assignment so every stage samples the value
   // from before the clock edge; blocking here would collapse the chain.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         // NOTE: the chain resets to the pin's idle level, not zero, so leaving
         // reset with an idle pin cannot fabricate an edge.
         sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign o_rise =  sync_q[SPI_SYNC_STAGES-1] & ~hist_q;
   assign o_fall = ~sync_q[SPI_SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
// SPI responder. Oversamples SCLK/CS_n/MOSI in the i_Clk domain, shifts one
// byte per 8 sample edges and reports each received byte with a one-cycle
// o_RX_DV pulse. Reply bytes come from a single-entry holding register
// (i_TX_DV / o_TX_Ready); when it is empty at a byte boundary DEFAULT_TX_BYTE
// is sent instead.
//
// Ports:
//   i_Clk, i_Rst            system clock, synchronous active-high reset
//   i_TX_Byte, i_TX_DV      reply byte and its load strobe
//   o_TX_Ready              holding register empty
//   o_RX_DV, o_RX_Byte      received-byte pulse and last complete byte
//   i_SPI_Clk, i_SPI_CS_n,
//   i_SPI_MOSI              asynchronous SPI pins
//   o_SPI_MISO, o_SPI_MISO_En  MISO data and its tristate enable
//   o_TX_Underrun, o_RX_Abort  only with SPI_SLAVE_UNDERRUN_DET_EN defined
//
// Optional build macro: SPI_SLAVE_UNDERRUN_DET_EN adds the underrun and
// abort pulse outputs.
// ----------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int         SPI_MODE        = 0,
   parameter logic [7:0] DEFAULT_TX_BYTE = 8'hFF
)(
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   input  logic       i_SPI_Clk,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_MOSI,
   output logic       o_SPI_MISO,
   output logic       o_SPI_MISO_En
`ifdef SPI_SLAVE_UNDERRUN_DET_EN
  ,output logic       o_TX_Underrun,
   output logic       o_RX_Abort
`endif
);

   localparam logic CPOL = f_cpol(SPI_MODE);
   localparam logic CPHA = f_cpha(SPI_MODE);

   // ---------------- input path ----------------
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SPI_SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic mosi_s;

   spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_async(i_SPI_Clk),
      .o_rise (sclk_rise),
      .o_fall (sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_async(i_SPI_CS_n),
      .o_rise (cs_rise),
      .o_fall (cs_fall)
   );

   // MOSI goes through the same depth as SCLK so data and clock stay aligned.
   assign mosi_sync_d = {mosi_sync_q[SPI_SYNC_STAGES-2:0], i_SPI_MOSI};
   assign mosi_s      = mosi_sync_q[SPI_SYNC_STAGES-1];

   logic lead_ev, trail_ev, sample_ev, shift_ev;
   assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
   assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
   assign sample_ev = CPHA ? trail_ev  : lead_ev;
   assign shift_ev  = CPHA ? lead_ev   : trail_ev;

   // ---------------- state ----------------
   spi_slave_state_t state_q, state_d;
   logic [7:0] tx_hold_q,  tx_hold_d;
   logic       tx_full_q,  tx_full_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [7:0] rx_byte_q,  rx_byte_d;
   logic       rx_dv_q,    rx_dv_d;
   logic       miso_q,     miso_d;
   logic       miso_en_q,  miso_en_d;

   logic       load_ev;
   logic [7:0] load_byte;
   logic       tx_capture;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned and infers a latch.
      state_d    = state_q;
      tx_hold_d  = tx_hold_q;
      tx_full_d  = tx_full_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      rx_byte_d  = rx_byte_q;
      rx_dv_d    = 1'b0;
      miso_d     = miso_q;
      miso_en_d  = miso_en_q;
      load_ev    = 1'b0;
      load_byte  = tx_full_q ? tx_hold_q : DEFAULT_TX_BYTE;

      case (state_q)
         IDLE: begin
            miso_d    = 1'b0;
            miso_en_d = 1'b0;
            if (cs_fall) begin
               state_d   = ACTIVE;
               load_ev   = 1'b1;
               miso_en_d = 1'b1;
               bit_cnt_d = 3'd0;
               // CPHA=0 must present bit7 before the first clock edge;
               // CPHA=1 waits for the first (leading) shift edge.
               if (CPHA) begin
                  tx_shift_d = load_byte;
               end else begin
                  miso_d     = load_byte[7];
                  tx_shift_d = {load_byte[6:0], 1'b0};
               end
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d   = IDLE;
               bit_cnt_d = 3'd0;
               miso_d    = 1'b0;
               miso_en_d = 1'b0;
            end else if (sample_ev) begin
               rx_shift_d = {rx_shift_q[5:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_byte_d  = {rx_shift_q, mosi_s};
                  rx_dv_d    = 1'b1;
                  // Reloaded byte is presented from the next shift edge on.
                  load_ev    = 1'b1;
                  tx_shift_d = load_byte;
               end
            end else if (shift_ev) begin
               miso_d     = tx_shift_q[7];
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase

      // A load frees the holding register in the same cycle, so a strobe that
      // coincides with a load is accepted after the old content is consumed.
      tx_capture = i_TX_DV && (!tx_full_q || load_ev);
      if (tx_capture) begin
         tx_hold_d = i_TX_Byte;
         tx_full_d = 1'b1;
      end else if (load_ev) begin
         tx_full_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q     <= IDLE;
         tx_hold_q   <= 8'h00;
         tx_full_q   <= 1'b0;
         tx_shift_q  <= 8'h00;
         rx_shift_q  <= 7'h00;
         bit_cnt_q   <= 3'd0;
         rx_byte_q   <= 8'h00;
         rx_dv_q     <= 1'b0;
         miso_q      <= 1'b0;
         miso_en_q   <= 1'b0;
         mosi_sync_q <= '0;
      end else begin
         state_q     <= state_d;
         tx_hold_q   <= tx_hold_d;
         tx_full_q   <= tx_full_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_byte_q   <= rx_byte_d;
         rx_dv_q     <= rx_dv_d;
         miso_q      <= miso_d;
         miso_en_q   <= miso_en_d;
         mosi_sync_q <= mosi_sync_d;
      end
   end

   assign o_TX_Ready    = ~tx_full_q;
   assign o_RX_DV       = rx_dv_q;
   assign o_RX_Byte     = rx_byte_q;
   assign o_SPI_MISO    = miso_q;
   assign o_SPI_MISO_En = miso_en_q;

`ifdef SPI_SLAVE_UNDERRUN_DET_EN
   // ever_q suppresses the underrun flag on the first CS-fall load when the
   // host has never queued anything since reset.
   logic ever_q, ever_d;
   logic underrun_q, underrun_d;
   logic abort_q, abort_d;

   always_comb begin
      ever_d     = ever_q | tx_capture;
      underrun_d = load_ev && !tx_full_q && (ever_q || (state_q == ACTIVE));
      abort_d    = (state_q == ACTIVE) && cs_rise && (bit_cnt_q != 3'd0);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         ever_q     <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         ever_q     <= ever_d;
         underrun_q <= underrun_d;
         abort_q    <= abort_d;
      end
   end

   assign o_TX_Underrun = underrun_q;
   assign o_RX_Abort    = abort_q;
`endif

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder (slave) that pairs with the team's SPI master on the same byte-level handshake. It oversamples the external SCLK, CS_n and MOSI pins in the i_Clk domain, shifts one byte per 8 sample edges, and returns received bytes with a 1-cycle o_RX_DV pulse. Reply data comes from a single-entry TX holding register loaded via i_TX_DV/o_TX_Ready. It sits between the board-level SPI pins and a register-file or command decoder.

Parameters:
SPI_MODE, 0, SPI mode 0..3; CPOL = mode 2 or 3, CPHA = mode 1 or 3.
DEFAULT_TX_BYTE, 8'hFF, byte shifted out when no TX byte is pending at a byte boundary.

Ports:
i_Clk  in  1  system clock; must be at least 8x SCLK frequency.
i_Rst  in  1  synchronous reset, active-high.
i_TX_Byte  in  8  reply byte.
i_TX_DV  in  1  1-cycle load strobe for i_TX_Byte.
o_TX_Ready  out  1  holding register empty.
o_RX_DV  out  1  1-cycle pulse when a byte completes.
o_RX_Byte  out  8  last complete byte received, MSB first.
i_SPI_Clk  in  1  SCLK pin, asynchronous.
i_SPI_CS_n  in  1  chip select pin, active-low, asynchronous.
i_SPI_MOSI  in  1  MOSI pin, asynchronous.
o_SPI_MISO  out  1  MISO data.
o_SPI_MISO_En  out  1  tristate enable; 1 only while the slave is selected.

Behaviour:
- One clock domain (i_Clk). Reset is synchronous and active-high (i_Rst).
- Reset values:
  - o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=8'h00, o_SPI_MISO=0, o_SPI_MISO_En=0.
  - Holding register empty; state IDLE.
  - Synchroniser flops preset to idle levels: SCLK=CPOL, CS_n=1, MOSI=0.
- Input path:
  - 2-flop synchroniser on SCLK, CS_n and MOSI, plus one history flop on SCLK and CS_n for edge detection.
  - Pin-to-detected-edge latency is 3 i_Clk.
- Edge roles:
  - Leading edge = rising if CPOL=0, else falling.
  - Sample edge = leading if CPHA=0, else trailing.
  - Shift edge = the opposite edge.
- FSM states:
  - IDLE: leave on CS_n synced fall. Load the TX shift register from the holding register if full (register then empties, o_TX_Ready=1 next cycle), else from DEFAULT_TX_BYTE. Set o_SPI_MISO_En=1, bit count=0. Go to ACTIVE.
  - ACTIVE: sample/shift edges as below. Return to IDLE on CS_n synced rise.
- Sample edge:
  - Shift synced MOSI into the RX shift register (MSB first); bit count +1.
  - On the 8th sample: o_RX_Byte updates and o_RX_DV=1 for one cycle, both 1 i_Clk after the detected edge. Bit count wraps to 0.
  - Also on the 8th sample, reload the TX shift register (holding register or DEFAULT_TX_BYTE), same rule as CS fall.
- MISO timing:
  - CPHA=0: bit7 is presented in the cycle after CS fall; each shift edge presents the next bit.
  - CPHA=1: the first shift edge after a load presents bit7; later shift edges present the next bit.
  - Both modes: bit7 of a reloaded byte appears on the first shift edge after the 8th sample.
- TX handshake:
  - i_TX_DV while o_TX_Ready=1 captures i_TX_Byte; o_TX_Ready=0 next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored.
  - i_TX_DV in the same cycle as a load event: the load consumes the old content, then the new byte is captured; o_TX_Ready stays 0.
- CS rise mid-byte:
  - Partial RX is discarded (no o_RX_DV) and bit count clears.
  - The byte already in the shift register is lost; the holding register keeps its content.
  - o_SPI_MISO_En=0 and o_SPI_MISO=0 the next cycle.
- SCLK edges while CS_n is high are ignored.
- i_Rst mid-transfer returns every register to its reset value in the next cycle.

Optional Feature:
Macro SPI_SLAVE_UNDERRUN_DET_EN.
- Defined: adds output o_TX_Underrun (1 bit). It pulses 1 cycle whenever a load event takes DEFAULT_TX_BYTE because the holding register is empty, excluding the CS-fall load when nothing was ever queued since reset. It also adds output o_RX_Abort, pulsed on CS rise with bit count != 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package spi_pkg:
  - Functions f_cpol(mode) and f_cpha(mode).
  - Enum spi_slave_state_t {IDLE, ACTIVE}.
  - Constant SPI_SYNC_STAGES=2.
- Sub-module spi_sync_edge: parameterised-reset-value 2-flop synchroniser plus rise/fall pulse outputs. Instantiated for SCLK and CS_n; MOSI uses sync only.

Test Plan:
- Mode 0, SCLK=i_Clk/8, preload 8'hA5, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; o_RX_Byte=8'h3C with a single o_RX_DV pulse; o_TX_Ready rises 1 cycle after CS fall.
- Modes 1, 2, 3 each with preload 8'h81, master sends 8'h7E -> o_RX_Byte=8'h7E; master captures 8'h81.
- Two-byte frame, mode 3, no second preload -> second MISO byte = 8'hFF; o_TX_Underrun pulses once (with macro defined); two o_RX_DV pulses.
- CS raised after 5 SCLK cycles -> no o_RX_DV, o_SPI_MISO_En=0 next cycle, o_RX_Abort pulses; next full byte 8'h55 is received correctly.
- i_TX_DV with 8'h11 then 8'h22 back-to-back while idle -> 8'h22 ignored; MISO byte = 8'h11.
- i_Rst asserted mid-byte -> all outputs at reset values the next cycle; a subsequent transfer is received correctly.
